srl_seq_32: RTL and testbench

SRL_SEQ_32 -- requirements
Module: srl_seq_32

---
 rtl/srl_seq_32.sv | 104 ++++++++++
 tb/tb_srl_seq_32.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/srl_seq_32.sv
// Multi-cycle 32-bit right shifter (MIPS SRL/SRA) built as a five-stage
// barrel shift, one stage per clock, so latency is fixed regardless of shamt.
module srl_seq_32 (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_start,
  input  logic [31:0] in_data_32,
  input  logic [4:0]  in_shamt_5,
  input  logic        in_arith,
  output logic        out_busy,
  output logic        out_done,
  output logic [31:0] out_shifted_data_32
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] work_q;
  logic [31:0] result_q;
  logic [4:0]  shamt_q;
  logic        arith_q;
  logic [2:0]  count_q;
  logic        busy_q;
  logic        done_q;

  logic        stage_en;
  logic [4:0]  stage_amt;
  logic [31:0] stage_fill;
  logic [31:0] stage_d;

  // Stage k shifts by 2^k when bit k of the captured shift amount is set;
  // the vacated upper bits are taken from the fill mask.
  always_comb begin
    stage_en  = 1'b0;
    stage_amt = 5'd0;
    case (count_q)
      3'd4: begin stage_en = shamt_q[4]; stage_amt = 5'd16; end
      3'd3: begin stage_en = shamt_q[3]; stage_amt = 5'd8;  end
      3'd2: begin stage_en = shamt_q[2]; stage_amt = 5'd4;  end
      3'd1: begin stage_en = shamt_q[1]; stage_amt = 5'd2;  end
      default: begin stage_en = shamt_q[0]; stage_amt = 5'd1; end
    endcase
    stage_fill = arith_q ? {32{work_q[31]}} : 32'h0000_0000;
    stage_d    = work_q;
    if (stage_en) begin
      stage_d = (work_q >> stage_amt) | (stage_fill & ~(32'hFFFF_FFFF >> stage_amt));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      work_q   <= 32'h0000_0000;
      result_q <= 32'h0000_0000;
      shamt_q  <= 5'd0;
      arith_q  <= 1'b0;
      count_q  <= 3'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_start) begin
            work_q  <= in_data_32;
            shamt_q <= in_shamt_5;
            arith_q <= in_arith;
            count_q <= 3'd4;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          work_q <= stage_d;
          if (count_q == 3'd0) begin
            result_q <= stage_d;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end else begin
            count_q <= count_q - 3'd1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign out_busy            = busy_q;
  assign out_done            = done_q;
  assign out_shifted_data_32 = result_q;

endmodule

// File: tb/tb_srl_seq_32.sv
// Directed and randomized checks of srl_seq_32: latency, busy window,
// request dropping while busy, and asynchronous reset abort.
module tb_srl_seq_32;

  logic        clk;
  logic        reset;
  logic        in_start;
  logic [31:0] in_data_32;
  logic [4:0]  in_shamt_5;
  logic        in_arith;
  logic        out_busy;
  logic        out_done;
  logic [31:0] out_shifted_data_32;

  int checks;
  int failures;

  srl_seq_32 dut (
    .clk                 (clk),
    .reset               (reset),
    .in_start            (in_start),
    .in_data_32          (in_data_32),
    .in_shamt_5          (in_shamt_5),
    .in_arith            (in_arith),
    .out_busy            (out_busy),
    .out_done            (out_done),
    .out_shifted_data_32 (out_shifted_data_32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference MIPS SRL/SRA using the language's own shift operators.
  function automatic logic [31:0] refShift(input logic [31:0] data, input logic [4:0] sh,
                                           input logic ar);
    logic signed [31:0] s;
    logic signed [31:0] r;
    s = data;
    if (ar) r = s >>> sh;
    else    r = s >> sh;
    return r;
  endfunction

  // Presents one request so that the next rising edge (E0) samples it.
  task automatic applyStimulus(input logic [31:0] data, input logic [4:0] sh, input logic ar);
    @(negedge clk);
    in_start   = 1'b1;
    in_data_32 = data;
    in_shamt_5 = sh;
    in_arith   = ar;
    @(posedge clk);
    #1 in_start = 1'b0;
  endtask

  // Watches n falling edges after E0; window index i is the cycle after edge E(i).
  task automatic observeWindow(input int n, input logic [7:0] pulseMask,
                               output int busyN, output int doneN, output int doneIdx,
                               output logic [31:0] res);
    busyN   = 0;
    doneN   = 0;
    doneIdx = -1;
    res     = 32'hDEAD_BEEF;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (out_busy) busyN++;
      if (out_done) begin
        doneN++;
        doneIdx = i;
        res = out_shifted_data_32;
      end
      if (i < 8 && pulseMask[i]) begin
        in_start   = 1'b1;
        in_data_32 = 32'h0BAD_F00D;
        in_shamt_5 = 5'd3;
        in_arith   = 1'b1;
      end else begin
        in_start = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    reset      = 1'b0;
    in_start   = 1'b0;
    in_data_32 = 32'h0;
    in_shamt_5 = 5'd0;
    in_arith   = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (out_busy !== 1'b0 || out_done !== 1'b0 || out_shifted_data_32 !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset_state busy=%b done=%b res=%h required 0/0/00000000",
               out_busy, out_done, out_shifted_data_32);
    end
    reset = 1'b1;
    in_data_32 = 32'hFFFF_FFFF;
    repeat (4) @(negedge clk);
    checks++;
    if (out_busy !== 1'b0 || out_done !== 1'b0 || out_shifted_data_32 !== 32'h0) begin
      failures++;
      $display("[TB] FAIL idle_hold busy=%b done=%b res=%h required 0/0/00000000",
               out_busy, out_done, out_shifted_data_32);
    end
  endtask

  task automatic test_srl();
    int busyN, doneN, doneIdx;
    logic [31:0] res;
    applyStimulus(32'h8000_0000, 5'd31, 1'b0);
    observeWindow(8, 8'h00, busyN, doneN, doneIdx, res);
    checks++;
    if (busyN !== 6) begin
      failures++;
      $display("[TB] FAIL srl_busy_cycles got %0d required 6", busyN);
    end
    checks++;
    if (doneN !== 1 || doneIdx !== 5) begin
      failures++;
      $display("[TB] FAIL srl_done_timing count=%0d idx=%0d required 1 at 5", doneN, doneIdx);
    end
    checks++;
    if (res !== 32'h0000_0001) begin
      failures++;
      $display("[TB] FAIL srl_result got %h required 00000001", res);
    end
    checks++;
    if (out_shifted_data_32 !== 32'h0000_0001) begin
      failures++;
      $display("[TB] FAIL srl_result_hold got %h required 00000001", out_shifted_data_32);
    end
  endtask

  task automatic test_sra();
    int busyN, doneN, doneIdx;
    logic [31:0] res;
    logic [31:0] dataV [3] = '{32'h8000_0000, 32'h7FFF_FFF0, 32'hA5A5_A5A5};
    logic [4:0]  shV   [3] = '{5'd31, 5'd4, 5'd1};
    logic [31:0] expV  [3] = '{32'hFFFF_FFFF, 32'h07FF_FFFF, 32'hD2D2_D2D2};
    for (int i = 0; i < 3; i++) begin
      applyStimulus(dataV[i], shV[i], 1'b1);
      observeWindow(7, 8'h00, busyN, doneN, doneIdx, res);
      checks++;
      if (res !== expV[i] || doneN !== 1) begin
        failures++;
        $display("[TB] FAIL sra_result[%0d] got %h (done=%0d) required %h (done=1)",
                 i, res, doneN, expV[i]);
      end
    end
    applyStimulus(32'hA5A5_A5A5, 5'd1, 1'b0);
    observeWindow(7, 8'h00, busyN, doneN, doneIdx, res);
    checks++;
    if (res !== 32'h52D2_D2D2) begin
      failures++;
      $display("[TB] FAIL srl_a5_result got %h required 52d2d2d2", res);
    end
  endtask

  task automatic test_shamt_zero();
    int busyN, doneN, doneIdx;
    logic [31:0] res;
    for (int a = 0; a < 2; a++) begin
      applyStimulus(32'h1234_5678, 5'd0, a[0]);
      observeWindow(7, 8'h00, busyN, doneN, doneIdx, res);
      checks++;
      if (res !== 32'h1234_5678 || doneIdx !== 5 || busyN !== 6) begin
        failures++;
        $display("[TB] FAIL shamt0[arith=%0d] res=%h idx=%0d busy=%0d required 12345678 5 6",
                 a, res, doneIdx, busyN);
      end
    end
  endtask

  task automatic test_busy_ignore();
    int busyN, doneN, doneIdx;
    logic [31:0] res;
    applyStimulus(32'hF000_0000, 5'd8, 1'b0);
    observeWindow(8, 8'b0010_0010, busyN, doneN, doneIdx, res);
    checks++;
    if (res !== 32'h00F0_0000) begin
      failures++;
      $display("[TB] FAIL busy_ignore_result got %h required 00f00000", res);
    end
    checks++;
    if (doneN !== 1 || busyN !== 6) begin
      failures++;
      $display("[TB] FAIL busy_ignore_pulses done=%0d busy=%0d required 1 6", doneN, busyN);
    end
  endtask

  task automatic test_reset_abort();
    int busyN, doneN, doneIdx;
    int doneSeen;
    logic [31:0] res;
    applyStimulus(32'hFFFF_0000, 5'd16, 1'b0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (out_busy !== 1'b0 || out_done !== 1'b0 || out_shifted_data_32 !== 32'h0) begin
      failures++;
      $display("[TB] FAIL abort_clear busy=%b done=%b res=%h required 0/0/00000000",
               out_busy, out_done, out_shifted_data_32);
    end
    doneSeen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (out_done) doneSeen++;
    end
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (out_done || out_busy) doneSeen++;
    end
    checks++;
    if (doneSeen !== 0) begin
      failures++;
      $display("[TB] FAIL abort_no_done got %0d activity cycles required 0", doneSeen);
    end
    applyStimulus(32'h0000_FFFF, 5'd4, 1'b0);
    observeWindow(7, 8'h00, busyN, doneN, doneIdx, res);
    checks++;
    if (res !== 32'h0000_0FFF || doneIdx !== 5) begin
      failures++;
      $display("[TB] FAIL abort_restart res=%h idx=%0d required 00000fff 5", res, doneIdx);
    end
  endtask

  task automatic test_back_to_back();
    int busyN, doneN, doneIdx;
    int badCount;
    logic [31:0] res, d, expected;
    logic [4:0] sh;
    logic ar;
    badCount = 0;
    for (int n = 0; n < 2000; n++) begin
      d  = $urandom;
      sh = 5'($urandom_range(0, 31));
      ar = 1'($urandom_range(0, 1));
      expected = refShift(d, sh, ar);
      applyStimulus(d, sh, ar);
      observeWindow(6, 8'h00, busyN, doneN, doneIdx, res);
      checks++;
      if (res !== expected || doneN !== 1 || doneIdx !== 5) begin
        failures++;
        badCount++;
        if (badCount <= 10)
          $display("[TB] FAIL random[%0d] d=%h sh=%0d ar=%0d got %h (done=%0d) required %h",
                   n, d, sh, ar, res, doneN, expected);
      end
    end
    @(negedge clk);
    checks++;
    if (out_busy !== 1'b0 || out_done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL random_tail busy=%b done=%b required 0/0", out_busy, out_done);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_srl();
    test_sra();
    test_shamt_zero();
    test_busy_ignore();
    test_reset_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
